uart_rx_deserializer: RTL and testbench

//  Serial receive front-end for one fabric UART channel. Sits directly upstream of
//  the UART Wishbone register block: consumes the UARTn_SIN_i pad signal and

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_deserializer_if.sv | 12 +
 rtl/uart_rx_fifo.sv | 45 ++++
 rtl/uart_rx_deserializer.sv | 153 +++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, error flag positions and helpers shared by the UART blocks.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam int ERR_FRAME = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_BREAK = 2;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS = 8;
  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: receive-side FIFO read port of one UART channel.
interface uart_rx_deserializer_if #(parameter int FIFO_ADR_WIDTH = 4);
  logic [7:0] Rx_Dat_o;
  logic [2:0] Rx_Err_o;
  logic Rx_Valid_o;
  logic Rx_Pop_i;
  logic [FIFO_ADR_WIDTH:0] Rx_Count_o;
  logic Rx_Ovr_o;
  logic Rx_Intr_o;
  modport master(output Rx_Dat_o, Rx_Err_o, Rx_Valid_o, Rx_Count_o, Rx_Ovr_o, Rx_Intr_o, input Rx_Pop_i);
  modport slave(input Rx_Dat_o, Rx_Err_o, Rx_Valid_o, Rx_Count_o, Rx_Ovr_o, Rx_Intr_o, output Rx_Pop_i);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO holding {err, data} receive words.
module uart_rx_fifo #(
  parameter int AW = 4,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(2**AW);
  assign count = cnt_q;
  assign rdata = empty ? '0 : mem_q[rd_q];
  // A pop frees the slot the simultaneous push lands in, so a full FIFO still accepts it
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  always_comb begin
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 16x oversampled UART receiver with glitch rejection,
// optional parity, framing/break detection and a show-ahead receive FIFO.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int FIFO_ADR_WIDTH = 4,
  parameter int INTR_THRESHOLD = 1
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST_N,
  input  logic                 Enable_i,
  input  logic [DIV_WIDTH-1:0] Divisor_i,
  input  logic                 Parity_En_i,
  input  logic                 Parity_Odd_i,
  input  logic                 Fifo_Flush_i,
  input  logic                 UART_SIN_i,
  uart_rx_deserializer_if.master rx
);
  localparam int AW = FIFO_ADR_WIDTH;
  rx_state_e state_q, state_d;
  logic [DIV_WIDTH-1:0] eff_div, div_q, div_d, tcnt_q, tcnt_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sr_q, sr_d;
  logic sin1_q, sin1_d, sin2_q, sin2_d, sinp_q, sinp_d, v7_q, v7_d, v8_q, v8_d;
  logic par_en_q, par_en_d, par_odd_q, par_odd_d, par_bit_q, par_bit_d, par_err_q, par_err_d;
  logic ovr_q, ovr_d, intr_q, intr_d;
  logic tick, vote, decide, bit_end, push, full, empty;
  logic [2:0] err;
  logic [10:0] head;
  logic [AW:0] count;
  assign eff_div = (Divisor_i == '0) ? DIV_WIDTH'(1) : Divisor_i;
  assign tick = tcnt_q == '0;
  assign vote = vote3(v7_q, v8_q, sin2_q);
  assign decide = tick && scnt_q == 4'd9;
  assign bit_end = tick && scnt_q == 4'(OVERSAMPLE-1);
  always_comb begin
    state_d = state_q;
    sin1_d = UART_SIN_i;
    sin2_d = sin1_q;
    sinp_d = sin2_q;
    div_d = div_q;
    tcnt_d = tcnt_q;
    scnt_d = scnt_q;
    bcnt_d = bcnt_q;
    sr_d = sr_q;
    v7_d = v7_q;
    v8_d = v8_q;
    par_en_d = par_en_q;
    par_odd_d = par_odd_q;
    par_bit_d = par_bit_q;
    par_err_d = par_err_q;
    push = 1'b0;
    err = '0;
    err[ERR_FRAME] = !vote;
    err[ERR_PARITY] = par_err_q;
    err[ERR_BREAK] = !vote && sr_q == '0 && !(par_en_q && par_bit_q);
    if (state_q != IDLE) begin
      tcnt_d = tick ? div_q - DIV_WIDTH'(1) : tcnt_q - DIV_WIDTH'(1);
      scnt_d = tick ? scnt_q + 4'd1 : scnt_q;
      v7_d = (tick && scnt_q == 4'd7) ? sin2_q : v7_q;
      v8_d = (tick && scnt_q == 4'd8) ? sin2_q : v8_q;
    end
    case (state_q)
      IDLE: begin
        tcnt_d = eff_div - DIV_WIDTH'(1);
        scnt_d = '0;
        bcnt_d = '0;
        if (sinp_q && !sin2_q) begin
          state_d = START;
          div_d = eff_div;
          par_en_d = Parity_En_i;
          par_odd_d = Parity_Odd_i;
          par_bit_d = 1'b0;
          par_err_d = 1'b0;
        end
      end
      START: state_d = (decide && vote) ? IDLE : bit_end ? DATA : START;
      DATA: begin
        sr_d = decide ? {vote, sr_q[7:1]} : sr_q;
        bcnt_d = bit_end ? bcnt_q + 3'd1 : bcnt_q;
        if (bit_end && bcnt_q == 3'(DATA_BITS-1)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (decide) begin
          par_bit_d = vote;
          par_err_d = (^sr_q ^ vote) != par_odd_q;
        end
        if (bit_end) state_d = STOP;
      end
      STOP: if (decide) begin
        push = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!Enable_i) begin
      state_d = IDLE;
      push = 1'b0;
    end
    ovr_d = !Fifo_Flush_i && (ovr_q || (push && full && !rx.Rx_Pop_i));
    intr_d = (count >= (AW+1)'(INTR_THRESHOLD)) || ovr_q || (!empty && |head[10:8]);
  end
  always_ff @(posedge WB_CLK or negedge WB_RST_N)
    if (!WB_RST_N) begin
      state_q <= IDLE;
      sin1_q <= 1'b1;
      sin2_q <= 1'b1;
      sinp_q <= 1'b1;
      div_q <= '0;
      tcnt_q <= '0;
      scnt_q <= '0;
      bcnt_q <= '0;
      sr_q <= '0;
      v7_q <= 1'b0;
      v8_q <= 1'b0;
      par_en_q <= 1'b0;
      par_odd_q <= 1'b0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      ovr_q <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sin1_q <= sin1_d;
      sin2_q <= sin2_d;
      sinp_q <= sinp_d;
      div_q <= div_d;
      tcnt_q <= tcnt_d;
      scnt_q <= scnt_d;
      bcnt_q <= bcnt_d;
      sr_q <= sr_d;
      v7_q <= v7_d;
      v8_q <= v8_d;
      par_en_q <= par_en_d;
      par_odd_q <= par_odd_d;
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
      ovr_q <= ovr_d;
      intr_q <= intr_d;
    end
  uart_rx_fifo #(.AW(AW), .W(11)) u_fifo (
    .clk(WB_CLK), .rst_n(WB_RST_N), .flush(Fifo_Flush_i), .push(push), .pop(rx.Rx_Pop_i),
    .wdata({err, sr_q}), .rdata(head), .count(count), .full(full), .empty(empty)
  );
  assign rx.Rx_Dat_o = head[7:0];
  assign rx.Rx_Err_o = head[10:8];
  assign rx.Rx_Valid_o = !empty;
  assign rx.Rx_Count_o = count;
  assign rx.Rx_Ovr_o = ovr_q;
  assign rx.Rx_Intr_o = intr_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed and randomized frames checked against a
// frame-level queue model of the receive FIFO.
module tb_uart_rx_deserializer;
  logic clk = 0, rst_n = 1, en = 0, pe = 0, po = 0, flush = 0, sin = 1;
  logic [15:0] div = 16'd4;
  int vectors = 0, miscompares = 0;
  logic [10:0] mq[$];
  logic movr = 0;
  always #5 clk = ~clk;
  uart_rx_deserializer_if #(.FIFO_ADR_WIDTH(4)) bus ();
  uart_rx_deserializer dut (
    .WB_CLK(clk), .WB_RST_N(rst_n), .Enable_i(en), .Divisor_i(div), .Parity_En_i(pe),
    .Parity_Odd_i(po), .Fifo_Flush_i(flush), .UART_SIN_i(sin), .rx(bus)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic int bitlen();
    return 16 * ((div == 0) ? 1 : int'(div));
  endfunction
  task automatic drive(logic v, int n);
    sin = v;
    cyc(n);
  endtask
  function automatic void model_push(logic [7:0] d, logic pbit, logic stopb);
    logic fe, perr, brk;
    fe = !stopb;
    perr = pe && ((^d ^ pbit) != po);
    brk = fe && d == 8'h00 && (!pe || !pbit);
    if (mq.size() < 16) mq.push_back({brk, perr, fe, d});
    else movr = 1;
  endfunction
  task automatic send(logic [7:0] d, logic pbit, logic stopb);
    int b = bitlen();
    drive(0, b);
    for (int i = 0; i < 8; i++) drive(d[i], b);
    if (pe) drive(pbit, b);
    drive(stopb, b);
    drive(1, 2 * b);
    model_push(d, pbit, stopb);
  endtask
  task automatic check_head(string tag);
    chk({tag, ".count"}, 32'(bus.Rx_Count_o), mq.size());
    chk({tag, ".valid"}, 32'(bus.Rx_Valid_o), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk({tag, ".dat"}, 32'(bus.Rx_Dat_o), 32'(mq[0][7:0]));
      chk({tag, ".err"}, 32'(bus.Rx_Err_o), 32'(mq[0][10:8]));
    end
    chk({tag, ".ovr"}, 32'(bus.Rx_Ovr_o), 32'(movr));
    chk({tag, ".intr"}, 32'(bus.Rx_Intr_o), 32'((mq.size() >= 1) || movr));
  endtask
  task automatic pop();
    bus.Rx_Pop_i = 1;
    cyc(1);
    bus.Rx_Pop_i = 0;
    if (mq.size() != 0) void'(mq.pop_front());
    cyc(2);
  endtask
  task automatic check_zero(string tag);
    chk({tag, ".dat0"}, 32'(bus.Rx_Dat_o), 0);
    chk({tag, ".err0"}, 32'(bus.Rx_Err_o), 0);
    check_head(tag);
  endtask
  initial begin
    logic [7:0] d;
    logic pbit, stopb;
    int b;
    bus.Rx_Pop_i = 0;
    #1 rst_n = 0;
    cyc(3);
    check_zero("reset");
    rst_n = 1;
    en = 1;
    cyc(4);
    check_zero("post_reset");
    b = bitlen();
    send(8'hA5, 0, 1);
    check_head("t1_a5");
    pop();
    check_head("t1_popped");
    pop();
    check_head("pop_empty");
    pe = 1;
    po = 0;
    send(8'h07, 0, 1);
    check_head("t2_bad_par");
    pop();
    send(8'h07, 1, 1);
    check_head("t2_good_par");
    pop();
    pe = 0;
    drive(0, 12 * b);
    mq.push_back(11'h500);
    check_head("t3_break");
    drive(1, 3 * b);
    check_head("t3_break_idle");
    pop();
    drive(0, b / 4);
    drive(1, 2 * b);
    check_head("t4_glitch");
    send(8'h3C, 0, 1);
    check_head("t4_3c");
    pop();
    for (int i = 0; i <= 16; i++) send(8'(i), 0, 1);
    check_head("t5_full");
    for (int i = 0; i < 15; i++) begin
      pop();
      check_head("t5_drain");
    end
    flush = 1;
    cyc(1);
    flush = 0;
    mq.delete();
    movr = 0;
    cyc(2);
    check_head("t5_flush");
    d = 8'hA5;
    drive(0, b);
    for (int i = 0; i < 3; i++) drive(d[i], b);
    drive(d[3], b / 2);
    en = 0;
    drive(d[3], b / 2);
    for (int i = 4; i < 8; i++) drive(d[i], b);
    drive(1, 2 * b);
    en = 1;
    cyc(2 * b);
    check_head("t6_enable");
    send(8'h55, 0, 1);
    check_head("t6_pre_reset");
    drive(0, b);
    drive(1, b / 2);
    rst_n = 0;
    sin = 1;
    cyc(2);
    mq.delete();
    movr = 0;
    check_zero("t6_reset");
    rst_n = 1;
    cyc(2 * b);
    send(8'h81, 0, 1);
    check_head("t6_after_reset");
    pop();
    for (int n = 0; n < 24; n++) begin
      div = 16'($urandom_range(0, 4));
      pe = 1'($urandom);
      po = 1'($urandom);
      d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      pbit = (^d ^ po) ^ ($urandom_range(0, 3) == 0);
      stopb = $urandom_range(0, 4) != 0;
      cyc(4);
      send(d, pbit, stopb);
      check_head("rand");
      pop();
      check_head("rand_pop");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
